// File: rtl/reg_file_weight_dbuf.sv
// reg_file_weight_dbuf: double-buffered weight register file, shadow bank loads while active bank drives all_weight
module reg_file_weight_dbuf #(
    parameter int WIDTH = 32,
    parameter int N_REG = 31,
    parameter int LANES = 2,
    parameter int DESC  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] in_data,
    input  logic                   swap,
    output logic                   loading,
    output logic                   load_done,
    output logic                   active_bank,
    output logic [WIDTH*N_REG-1:0] all_weight
);
    localparam int BEATS = (N_REG + LANES - 1) / LANES;
    localparam int CW = $clog2(BEATS + 1);
    localparam int AW = N_REG > 1 ? $clog2(N_REG) : 1;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] bank [2][N_REG];
    logic [AW-1:0] wa [LANES];
    logic [LANES-1:0] wen;
    assign in_ready = state == LOAD;
    assign loading = state == LOAD;
    assign load_done = state == FULL;
    always_comb begin
        wen = '0;
        for (int k = 0; k < LANES; k++) begin
            wen[k] = int'(cnt) * LANES + (DESC != 0 ? LANES - 1 - k : k) < N_REG;
            wa[k] = AW'(DESC != 0 ? N_REG - 1 - int'(cnt) * LANES - (LANES - 1 - k) : int'(cnt) * LANES + k);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            active_bank <= 1'b0;
            for (int g = 0; g < N_REG; g++) begin
                bank[0][g] <= '0;
                bank[1][g] <= '0;
            end
        end else if (state == FULL && swap) begin
            active_bank <= ~active_bank;
            state <= IDLE;
        end else if (start) begin
            state <= LOAD;
            cnt <= '0;
            for (int g = 0; g < N_REG; g++) bank[~active_bank][g] <= '0;
        end else if (state == LOAD && in_valid) begin
            for (int k = 0; k < LANES; k++)
                if (wen[k]) bank[~active_bank][wa[k]] <= in_data[k*WIDTH +: WIDTH];
            cnt <= cnt == CW'(BEATS) ? cnt : cnt + 1'b1;
            if (cnt == CW'(BEATS - 1)) state <= FULL;
        end
    end
    always_comb begin
        all_weight = '0;
        for (int g = 0; g < N_REG; g++) all_weight[g*WIDTH +: WIDTH] = bank[active_bank][g];
    end
endmodule

// File: tb/tb_reg_file_weight_dbuf.sv
// tb_reg_file_weight_dbuf: three configurations driven in lockstep, checked against a word-stream model
module tb_reg_file_weight_dbuf;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0, start = 1'b0, swap = 1'b0, in_valid = 1'b0;
    logic [127:0] ind [3];
    logic rdy [3], ld [3], dn [3], ab [3];
    logic [991:0] aw0, aw2;
    logic [1023:0] aw1;
    logic [1023:0] aw [3];
    assign aw[0] = {32'b0, aw0};
    assign aw[1] = aw1;
    assign aw[2] = {32'b0, aw2};

    reg_file_weight_dbuf #(.WIDTH(32), .N_REG(31), .LANES(2), .DESC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(ind[0][63:0]), .swap(swap), .loading(ld[0]), .load_done(dn[0]),
        .active_bank(ab[0]), .all_weight(aw0));
    reg_file_weight_dbuf #(.WIDTH(32), .N_REG(32), .LANES(3), .DESC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(ind[1][95:0]), .swap(swap), .loading(ld[1]), .load_done(dn[1]),
        .active_bank(ab[1]), .all_weight(aw1));
    reg_file_weight_dbuf #(.WIDTH(32), .N_REG(31), .LANES(4), .DESC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_data(ind[2]), .swap(swap), .loading(ld[2]), .load_done(dn[2]),
        .active_bank(ab[2]), .all_weight(aw2));

    localparam int NR [3] = '{31, 32, 31};
    localparam int LN [3] = '{2, 3, 4};
    localparam int DS [3] = '{1, 0, 1};
    localparam int BT [3] = '{16, 11, 8};
    int checks = 0, errors = 0;
    int mst [3], mcnt [3], mact [3], sc [3];
    logic [31:0] ew [3][32];
    logic [31:0] strm [3][40];

    typedef struct {
        logic rst_n, start, swap, valid;
        logic e_rdy, e_done, e_act;
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h exp %0h at %0t", nm, d, got, exp, $time);
        end
    endtask

    task automatic chk_aw(input int d);
        int bad = -1;
        for (int g = 0; g < NR[d]; g++)
            if (bad < 0 && aw[d][g*32 +: 32] !== ew[d][g]) bad = g;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL all_weight dut%0d word %0d got %0h exp %0h at %0t",
                     d, bad, aw[d][bad*32 +: 32], ew[d][bad], $time);
        end
    endtask

    // Model: beats append lanes to a word stream (top lane first when descending);
    // stream word j lands at address j (ascending) or N-1-j (descending), excess words are lost.
    task automatic model_step(input int d);
        if (!rst_n) begin
            mst[d] = 0; mcnt[d] = 0; mact[d] = 0; sc[d] = 0;
            for (int g = 0; g < 32; g++) ew[d][g] = 32'h0;
        end else if (mst[d] == 2 && swap) begin
            mact[d] ^= 1;
            mst[d] = 0;
            for (int j = 0; j < NR[d]; j++)
                ew[d][DS[d] != 0 ? NR[d] - 1 - j : j] = j < sc[d] ? strm[d][j] : 32'h0;
        end else if (start) begin
            mst[d] = 1; mcnt[d] = 0; sc[d] = 0;
        end else if (mst[d] == 1 && in_valid) begin
            for (int i = 0; i < LN[d]; i++) begin
                strm[d][sc[d]] = ind[d][(DS[d] != 0 ? LN[d] - 1 - i : i) * 32 +: 32];
                sc[d]++;
            end
            mcnt[d]++;
            if (mcnt[d] == BT[d]) mst[d] = 2;
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 3; d++) model_step(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("in_ready", d, 32'(rdy[d]), 32'(mst[d] == 1));
            chk("loading", d, 32'(ld[d]), 32'(mst[d] == 1));
            chk("load_done", d, 32'(dn[d]), 32'(mst[d] == 2));
            chk("active_bank", d, 32'(ab[d]), 32'(mact[d]));
            chk_aw(d);
        end
    endtask

    task automatic rand_data();
        for (int d = 0; d < 3; d++) ind[d] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic load_beats(input int n);
        in_valid = 1'b1;
        for (int b = 0; b < n; b++) begin
            rand_data();
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_swap();
        swap = 1'b1; tick(); swap = 1'b0;
    endtask

    initial begin
        int n, cyc, bad;
        rand_data();
        tv[0] = '{rst_n: 0, start: 0, swap: 0, valid: 0, e_rdy: 0, e_done: 0, e_act: 0};
        tv[1] = '{rst_n: 0, start: 1, swap: 1, valid: 1, e_rdy: 0, e_done: 0, e_act: 0};
        tv[2] = '{rst_n: 1, start: 0, swap: 1, valid: 1, e_rdy: 0, e_done: 0, e_act: 0};
        tv[3] = '{rst_n: 1, start: 1, swap: 0, valid: 0, e_rdy: 1, e_done: 0, e_act: 0};
        tv[4] = '{rst_n: 1, start: 0, swap: 1, valid: 0, e_rdy: 1, e_done: 0, e_act: 0};
        tv[5] = '{rst_n: 1, start: 1, swap: 1, valid: 1, e_rdy: 1, e_done: 0, e_act: 0};
        for (int i = 0; i < 6; i++) begin
            rst_n = tv[i].rst_n; start = tv[i].start; swap = tv[i].swap; in_valid = tv[i].valid;
            tick();
            chk("tv_ready", i, 32'(rdy[0]), 32'(tv[i].e_rdy));
            chk("tv_done", i, 32'(dn[0]), 32'(tv[i].e_done));
            chk("tv_act", i, 32'(ab[0]), 32'(tv[i].e_act));
        end
        start = 1'b0; swap = 1'b0; in_valid = 1'b0;

        // Default 16-beat load with known words, then swap
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pulse_start();
        in_valid = 1'b1;
        for (int b = 0; b < 16; b++) begin
            rand_data();
            ind[0][63:32] = 32'(100 + 2 * b);
            ind[0][31:0] = 32'(101 + 2 * b);
            tick();
        end
        in_valid = 1'b0;
        pulse_swap();
        bad = -1;
        for (int g = 0; g < 31; g++) if (bad < 0 && aw0[g*32 +: 32] !== 32'(130 - g)) bad = g;
        chk("t1_first_bad_word", 0, 32'(bad), 32'hffffffff);
        chk("t1_active", 0, 32'(ab[0]), 32'd1);

        // Backpressure: valid every other cycle
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pulse_start();
        n = 0; cyc = 0;
        while (!dn[0] && cyc < 100) begin
            in_valid = cyc % 2 == 0;
            rand_data();
            if (in_valid && rdy[0]) n++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("t2_transfers", 0, 32'(n), 32'd16);
        chk("t2_done", 0, 32'(dn[0]), 32'd1);
        chk("t2_ready_full", 0, 32'(rdy[0]), 32'd0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        pulse_swap();

        // Double buffering: A active while B loads
        pulse_start(); load_beats(16); pulse_swap();
        pulse_start(); load_beats(16); tick(); pulse_swap();

        // swap ignored in LOAD, restart at beat 7
        pulse_start();
        swap = 1'b1; load_beats(7); swap = 1'b0;
        pulse_start(); load_beats(16); pulse_swap();
        pulse_start(); load_beats(16); pulse_swap();

        // Reset mid-load at beat 5
        pulse_start(); load_beats(5);
        rst_n = 1'b0; in_valid = 1'b1; tick(); in_valid = 1'b0; rst_n = 1'b1;
        chk("t5_ready", 0, 32'(rdy[0]), 32'd0);
        chk("t5_done", 0, 32'(dn[0]), 32'd0);
        chk("t5_act", 0, 32'(ab[0]), 32'd0);
        chk("t5_zero", 0, 32'(aw0 == '0), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            start = $urandom_range(0, 24) == 0;
            swap = $urandom_range(0, 5) == 0;
            in_valid = $urandom_range(0, 2) != 0;
            rst_n = $urandom_range(0, 300) != 0;
            rand_data();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
